// File: rtl/otter_io_pkg.sv
// otter_io_pkg: shared address map constants and bus word type for the OTTER I/O bank
package otter_io_pkg;
  localparam logic [31:0] IO_BASE   = 32'h1100_0000;
  localparam logic [31:0] IO_STRIDE = 32'h20;
  localparam logic [31:0] PEND_OFS  = 32'h100;
  localparam logic [31:0] MASK_OFS  = 32'h104;
  typedef logic [31:0] io_word_t;
endpackage

// File: rtl/otter_sync2.sv
// otter_sync2: two-flop pin synchroniser with a one-cycle-delayed copy for change detection
module otter_sync2 #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         chg
);
  logic [W-1:0] s1_q, s2_q, prev_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end
  assign q   = s2_q;
  assign chg = |(s2_q ^ prev_q);
endmodule

// File: rtl/otter_mmio_bank.sv
// otter_mmio_bank: parametrised IOBUS register bank with synchronised inputs, registered outputs,
// sticky change-pending bits, an interrupt mask and a registered IRQ
module otter_mmio_bank
  import otter_io_pkg::*;
#(
  parameter logic [31:0]       BASE_ADDR = IO_BASE,
  parameter logic [31:0]       STRIDE    = IO_STRIDE,
  parameter int                NUM_IN    = 2,
  parameter int                NUM_OUT   = 4,
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] OUT_RST   = '0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [31:0]               IOBUS_ADDR,
  input  logic [31:0]               IOBUS_OUT,
  input  logic                      IOBUS_WR,
  output logic [31:0]               IOBUS_IN,
  input  logic [NUM_IN*DATA_W-1:0]  PORT_IN,
  output logic [NUM_OUT*DATA_W-1:0] PORT_OUT,
  output logic                      IRQ
);
  logic [NUM_IN*DATA_W-1:0] sync_val;
  logic [NUM_IN-1:0]        chg, pend_q, pend_d, mask_q, w1c;
  io_word_t                 in_word [NUM_IN];
  io_word_t                 out_word [NUM_OUT];
  logic                     pend_hit, mask_hit, irq_q;
  logic                     unused_wr;
  assign pend_hit  = IOBUS_ADDR == BASE_ADDR + PEND_OFS;
  assign mask_hit  = IOBUS_ADDR == BASE_ADDR + MASK_OFS;
  assign unused_wr = ^IOBUS_OUT;
  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    logic hit;
    otter_sync2 #(.W(DATA_W)) u_sync (
      .CLK(CLK),
      .RST(RST),
      .d(PORT_IN[i*DATA_W +: DATA_W]),
      .q(sync_val[i*DATA_W +: DATA_W]),
      .chg(chg[i])
    );
    assign hit        = IOBUS_ADDR == BASE_ADDR + 32'(i) * STRIDE;
    assign in_word[i] = hit ? io_word_t'(sync_val[i*DATA_W +: DATA_W]) : '0;
  end
  for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
    logic              hit;
    logic [DATA_W-1:0] out_q;
    assign hit = IOBUS_ADDR == BASE_ADDR + 32'(NUM_IN + j) * STRIDE;
    always_ff @(posedge CLK) begin
      if (RST) out_q <= OUT_RST;
      else if (IOBUS_WR && hit) out_q <= IOBUS_OUT[DATA_W-1:0];
    end
    assign PORT_OUT[j*DATA_W +: DATA_W] = out_q;
    assign out_word[j] = hit ? io_word_t'(out_q) : '0;
  end
  // A change arriving in the same cycle as its clear keeps the bit set
  assign w1c    = (IOBUS_WR && pend_hit) ? IOBUS_OUT[NUM_IN-1:0] : '0;
  assign pend_d = (pend_q & ~w1c) | chg;
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (IOBUS_WR && mask_hit) mask_q <= IOBUS_OUT[NUM_IN-1:0];
      irq_q  <= |(pend_q & mask_q);
    end
  end
  assign IRQ = irq_q;
  always_comb begin
    IOBUS_IN = (pend_hit ? io_word_t'(pend_q) : '0) | (mask_hit ? io_word_t'(mask_q) : '0);
    for (int i = 0; i < NUM_IN; i++) IOBUS_IN = IOBUS_IN | in_word[i];
    for (int j = 0; j < NUM_OUT; j++) IOBUS_IN = IOBUS_IN | out_word[j];
  end
endmodule

// File: tb/tb_otter_mmio_bank.sv
// tb_otter_mmio_bank: directed checks of map, reset, input path, pending/mask/IRQ timing
module tb_otter_mmio_bank;
  localparam logic [31:0] B = 32'h1100_0000;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] IOBUS_ADDR = '0;
  logic [31:0] IOBUS_OUT = '0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_IN;
  logic [31:0] PORT_IN = '0;
  logic [63:0] PORT_OUT;
  logic        IRQ;
  int          total = 0;
  int          passed = 0;
  otter_mmio_bank dut (
    .CLK(CLK),
    .RST(RST),
    .IOBUS_ADDR(IOBUS_ADDR),
    .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR),
    .IOBUS_IN(IOBUS_IN),
    .PORT_IN(PORT_IN),
    .PORT_OUT(PORT_OUT),
    .IRQ(IRQ)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    tick();
    IOBUS_WR   = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    IOBUS_ADDR = a;
    #1;
    chk(tag, IOBUS_IN, exp);
  endtask
  initial begin
    IOBUS_ADDR = B + 32'h40;
    IOBUS_OUT  = 32'h0000_BEEF;
    IOBUS_WR   = 1'b1;
    tick();
    tick();
    IOBUS_WR = 1'b0;
    chk("rst_port_out", PORT_OUT, 64'h0);
    chk("rst_irq", IRQ, 0);
    rd("rst_pend", B + 32'h100, 0);
    rd("rst_mask", B + 32'h104, 0);
    RST = 1'b0;
    tick();
    chk("wr_during_rst_dropped", PORT_OUT, 64'h0);
    wr(B + 32'h60, 32'h1234_ABCD);
    chk("out1_value", PORT_OUT[31:16], 16'hABCD);
    rd("out1_readback", B + 32'h60, 32'h0000_ABCD);
    wr(B + 32'h40, 32'hFFFF_0001);
    wr(B + 32'hA0, 32'h0000_5A5A);
    chk("out_all", PORT_OUT, 64'h5A5A_0000_ABCD_0001);
    rd("out3_readback", B + 32'hA0, 32'h0000_5A5A);
    rd("pend_idle", B + 32'h100, 0);
    PORT_IN[15:0] = 16'h0005;
    tick();
    rd("in0_after_edge1", B, 0);
    tick();
    rd("in0_after_edge2", B, 5);
    rd("pend_after_edge2", B + 32'h100, 0);
    tick();
    rd("pend_after_edge3", B + 32'h100, 1);
    chk("irq_masked", IRQ, 0);
    wr(B + 32'h104, 32'h1);
    chk("irq_mask_lat", IRQ, 0);
    rd("mask_readback", B + 32'h104, 1);
    tick();
    chk("irq_set", IRQ, 1);
    wr(B + 32'h100, 32'h1);
    rd("pend_cleared", B + 32'h100, 0);
    chk("irq_clr_lat", IRQ, 1);
    tick();
    chk("irq_cleared", IRQ, 0);
    PORT_IN[31:16] = 16'h0003;
    tick();
    tick();
    tick();
    rd("pend_in1", B + 32'h100, 2);
    rd("in1_read", B + 32'h20, 3);
    PORT_IN[15:0] = 16'h0007;
    tick();
    tick();
    wr(B + 32'h100, 32'h3);
    rd("w1c_set_wins", B + 32'h100, 1);
    tick();
    chk("irq_after_race", IRQ, 1);
    wr(B + 32'h104, 32'h2);
    rd("mask_keeps_pend", B + 32'h100, 1);
    chk("irq_mask_change_lat", IRQ, 1);
    tick();
    chk("irq_masked_off", IRQ, 0);
    wr(B, 32'hFFFF_FFFF);
    wr(B + 32'h400, 32'hFFFF_FFFF);
    chk("ignored_writes", PORT_OUT, 64'h5A5A_0000_ABCD_0001);
    rd("in0_unchanged", B, 7);
    rd("unmapped_read", B + 32'h400, 0);
    rd("pend_final", B + 32'h100, 1);
    rd("mask_final", B + 32'h104, 2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
